// File: rtl/eight_data_decompress_unit.sv
// eight_data_decompress_unit
// Expands one packed compressed block (8 variable-length fields plus 8 tags)
// back into 8 full DATA_WIDTH words. Decoding is serial, one word per cycle,
// through a right-shifting register that always presents the next field at
// its low end. The input and output each use a valid/ready handshake, and the
// two sides never overlap: a new block is taken only after the previous
// result has been consumed.

module eight_data_decompress_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 2,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic [DATA_WIDTH*8-1:0]   dataIn,
  input  logic [TAG_WIDTH*8-1:0]    tagIn,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [DATA_WIDTH*8-1:0]   dataOut,
  output logic [LEN_WIDTH:0]        usedBits
);

  localparam int BLOCK_WIDTH = DATA_WIDTH * 8;
  localparam int QUARTER     = DATA_WIDTH / 4;
  localparam int HALF        = DATA_WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Number of packed bits a field occupies for a given tag.
  function automatic logic [LEN_WIDTH-1:0] tag_length(input logic [1:0] tag);
    logic [LEN_WIDTH-1:0] len;
    case (tag)
      2'b00:   len = LEN_WIDTH'(0);
      2'b01:   len = LEN_WIDTH'(QUARTER);
      2'b10:   len = LEN_WIDTH'(HALF);
      2'b11:   len = LEN_WIDTH'(DATA_WIDTH);
      default: len = LEN_WIDTH'(DATA_WIDTH);
    endcase
    return len;
  endfunction

  // Rebuild a full word from the low bits of the shift register. Bits above
  // the field length are ignored so trailing packed data cannot leak in.
  function automatic logic [DATA_WIDTH-1:0] expand_word(
    input logic [1:0]            tag,
    input logic [DATA_WIDTH-1:0] bits
  );
    logic [DATA_WIDTH-1:0] word;
    case (tag)
      2'b00:   word = {DATA_WIDTH{1'b0}};
      2'b01:   word = {{(DATA_WIDTH-QUARTER){bits[QUARTER-1]}}, bits[QUARTER-1:0]};
      2'b10:   word = {{(DATA_WIDTH-HALF){bits[HALF-1]}}, bits[HALF-1:0]};
      2'b11:   word = bits;
      default: word = bits;
    endcase
    return word;
  endfunction

  state_t                     state;
  state_t                     next_state;
  logic [BLOCK_WIDTH-1:0]     shift_reg;
  logic [TAG_WIDTH*8-1:0]     tag_reg;
  logic [2:0]                 idx;
  logic [TAG_WIDTH-1:0]       cur_tag;
  logic [LEN_WIDTH-1:0]       cur_len;
  logic [DATA_WIDTH-1:0]      cur_word;

  // Field decode for the slot currently addressed by idx.
  always_comb begin
    cur_tag  = tag_reg[idx*TAG_WIDTH +: TAG_WIDTH];
    cur_len  = tag_length(cur_tag[1:0]);
    cur_word = expand_word(cur_tag[1:0], shift_reg[DATA_WIDTH-1:0]);
  end

  // Next-state logic: accept in IDLE, eight decode steps, hold in DONE until consumed.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (inValid) begin
          next_state = DECODE;
        end else begin
          next_state = IDLE;
        end
      end
      DECODE: begin
        if (idx == 3'd7) begin
          next_state = DONE;
        end else begin
          next_state = DECODE;
        end
      end
      DONE: begin
        if (outReady) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register with registered handshake flags decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      inReady  <= 1'b1;
      outValid <= 1'b0;
    end else begin
      state    <= next_state;
      inReady  <= (next_state == IDLE);
      outValid <= (next_state == DONE);
    end
  end

  // Datapath: load on accept, then write one slot and consume one field per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= {BLOCK_WIDTH{1'b0}};
      tag_reg   <= {(TAG_WIDTH*8){1'b0}};
      idx       <= 3'd0;
      usedBits  <= {(LEN_WIDTH+1){1'b0}};
      dataOut   <= {BLOCK_WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            shift_reg <= dataIn;
            tag_reg   <= tagIn;
            idx       <= 3'd0;
            usedBits  <= {(LEN_WIDTH+1){1'b0}};
            dataOut   <= {BLOCK_WIDTH{1'b0}};
          end
        end
        DECODE: begin
          dataOut[idx*DATA_WIDTH +: DATA_WIDTH] <= cur_word;
          shift_reg <= shift_reg >> cur_len;
          usedBits  <= usedBits + {1'b0, cur_len};
          idx       <= idx + 3'd1;
        end
        default: begin
          shift_reg <= shift_reg;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eight_data_decompress_unit.sv
// Bench for eight_data_decompress_unit: directed blocks, back-pressure,
// mid-decode reset and a random round trip through a compressor model.
// Expected results are queued on accept and compared on each output handshake.

module tb_eight_data_decompress_unit;

  localparam int DW = 32;
  localparam int TW = 2;
  localparam int LW = 8;
  localparam int BW = DW * 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           inValid;
  logic           inReady;
  logic [BW-1:0]  dataIn;
  logic [TW*8-1:0] tagIn;
  logic           outValid;
  logic           outReady;
  logic [BW-1:0]  dataOut;
  logic [LW:0]    usedBits;

  typedef struct {
    logic [BW-1:0] data;
    logic [LW:0]   used;
    int            acc;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            cycle = 0;
  int            n_out = 0;
  bit            seen = 1'b0;
  logic [BW-1:0] next_data;
  logic [LW:0]   next_used;

  eight_data_decompress_unit #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .dataIn(dataIn), .tagIn(tagIn), .outValid(outValid), .outReady(outReady),
    .dataOut(dataOut), .usedBits(usedBits)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_value(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*DW +: DW] = $urandom;
    return r;
  endfunction

  // Golden compressor: smallest encoding per word, fields packed LSB first,
  // everything above the used length filled with random junk.
  function automatic void compress(input logic [BW-1:0] words, output logic [BW-1:0] pk,
                                   output logic [TW*8-1:0] tg, output logic [LW:0] used);
    logic [DW-1:0] w;
    logic [1:0]    t;
    int            len;
    int            off;
    logic [BW-1:0] one;
    logic [BW-1:0] mask;
    one = BW'(1);
    off = 0;
    pk = '0;
    tg = '0;
    for (int i = 0; i < 8; i++) begin
      w = words[i*DW +: DW];
      if (w == 32'd0) begin
        t = 2'b00; len = 0;
      end else if (w == {{24{w[7]}}, w[7:0]}) begin
        t = 2'b01; len = 8;
      end else if (w == {{16{w[15]}}, w[15:0]}) begin
        t = 2'b10; len = 16;
      end else begin
        t = 2'b11; len = 32;
      end
      tg[i*2 +: 2] = t;
      pk = pk | ((BW'(w) & ((one << len) - one)) << off);
      off = off + len;
    end
    mask = (one << off) - one;
    pk = pk | (rand_block() & ~mask);
    used = (LW+1)'(off);
  endfunction

  // Scoreboard: push on accept, check latency and pop/compare on output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
        seen = 1'b0;
      end else begin
        if (outValid) begin
          if (exp_q.size() == 0) begin
            check_value("spurious_out", BW'(exp_q.size()), BW'(1));
          end else begin
            if (!seen) begin
              check_value("latency", BW'(cycle - exp_q[0].acc), BW'(8));
              seen = 1'b1;
            end
            if (outReady) begin
              check_value("data", dataOut, exp_q[0].data);
              check_value("used", BW'(usedBits), BW'(exp_q[0].used));
              void'(exp_q.pop_front());
              seen = 1'b0;
              n_out++;
            end
          end
        end
        if (inValid && inReady) begin
          exp_q.push_back('{data: next_data, used: next_used, acc: cycle + 1});
        end
      end
    end
  end

  // Drive one block and wait (bounded) for it to be accepted; inValid is left high.
  task automatic send_block(input logic [BW-1:0] d, input logic [TW*8-1:0] t,
                            input logic [BW-1:0] ed, input logic [LW:0] eu);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    next_data = ed;
    next_used = eu;
    inValid = 1'b1;
    dataIn = d;
    tagIn = t;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = inReady;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check_value("accept_timeout", BW'(ok), BW'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_value("drain", BW'(exp_q.size()), BW'(0));
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!outValid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_value("valid_wait", BW'(outValid), BW'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0]   d1;
    logic [BW-1:0]   d;
    logic [BW-1:0]   e;
    logic [BW-1:0]   words;
    logic [BW-1:0]   pk;
    logic [TW*8-1:0] tg;
    logic [LW:0]     used;
    logic [DW-1:0]   w;
    logic [DW-1:0]   r;
    int              base;

    reset = 1'b0;
    inValid = 1'b0;
    outReady = 1'b0;
    dataIn = '0;
    tagIn = '0;
    next_data = '0;
    next_used = '0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_out_valid", BW'(outValid), BW'(0));
    check_value("rst_in_ready", BW'(inReady), BW'(1));
    check_value("rst_data", dataOut, BW'(0));
    check_value("rst_used", BW'(usedBits), BW'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: all raw words, full length
    for (int i = 0; i < 8; i++) d1[i*DW +: DW] = DW'(i);
    outReady = 1'b1;
    send_block(d1, 16'hFFFF, d1, 9'd256);
    inValid = 1'b0;
    drain();

    // 2: all zero tags ignore the data entirely
    send_block({BW{1'b1}}, 16'h0000, BW'(0), 9'd0);
    inValid = 1'b0;
    drain();

    // 3: mixed sign-extend fields with junk above bit 24
    d = rand_block();
    d[23:0] = 24'h123480;
    e = '0;
    e[63:0] = 64'h00001234_FFFFFF80;
    send_block(d, 16'h0009, e, 9'd24);
    inValid = 1'b0;
    drain();

    // 4: back-pressure in DONE, stray input ignored
    outReady = 1'b0;
    d = rand_block();
    d[23:0] = 24'h80017F;
    e = '0;
    e[63:0] = 64'hFFFF8001_0000007F;
    send_block(d, 16'h0009, e, 9'd24);
    inValid = 1'b0;
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      inValid = (k == 2);
      dataIn = {BW{1'b1}};
      tagIn = 16'hFFFF;
      @(posedge clk);
      #1;
      check_value("hold_data", dataOut, e);
      check_value("hold_used", BW'(usedBits), BW'(24));
      check_value("hold_in_ready", BW'(inReady), BW'(0));
      check_value("hold_out_valid", BW'(outValid), BW'(1));
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    check_value("release_in_ready", BW'(inReady), BW'(1));
    check_value("release_out_valid", BW'(outValid), BW'(0));
    repeat (12) @(posedge clk);
    #1;
    drain();

    // 5: reset in the middle of decoding (idx == 4)
    send_block(d1, 16'hFFFF, d1, 9'd256);
    inValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_value("mid_rst_out_valid", BW'(outValid), BW'(0));
    check_value("mid_rst_data", dataOut, BW'(0));
    check_value("mid_rst_used", BW'(usedBits), BW'(0));
    @(posedge clk);
    #1;
    check_value("mid_rst_in_ready", BW'(inReady), BW'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_block(d1, 16'hFFFF, d1, 9'd256);
    inValid = 1'b0;
    drain();

    // 6: 200 random blocks back to back through the compressor model
    base = n_out;
    outReady = 1'b1;
    for (int b = 0; b < 200; b++) begin
      for (int i = 0; i < 8; i++) begin
        r = $urandom;
        case ($urandom_range(0, 3))
          0:       w = 32'd0;
          1:       w = {{24{r[7]}}, r[7:0]};
          2:       w = {{16{r[15]}}, r[15:0]};
          default: w = r;
        endcase
        words[i*DW +: DW] = w;
      end
      compress(words, pk, tg, used);
      send_block(pk, tg, words, used);
    end
    inValid = 1'b0;
    drain();
    check_value("block_count", BW'(n_out - base), BW'(200));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
